// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS x^4+x^3+1 types, defaults and tap predictor
package prbs_pkg;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_state_t;

    // Defaults shared with the lfsr generator: x^4 + x^3 + 1
    localparam int PRBS_WIDTH = 4;
    localparam int PRBS_TAP_A = 4;
    localparam int PRBS_TAP_B = 3;

    // History is zero-extended to 32 bits; taps are 1-based, h[1] newest at bit 0
    function automatic logic prbs_predict(input logic [31:0] h,
                                          input int          tap_a,
                                          input int          tap_b);
        return h[tap_a-1] ^ h[tap_b-1];
    endfunction

endpackage

// File: rtl/prbs_win_mon.sv
// rtl/prbs_win_mon.sv - per-window error counter that signals loss of lock
module prbs_win_mon
    import prbs_pkg::*;
#(
    parameter int WINDOW    = 16,
    parameter int ERR_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic active,
    input  logic bit_err,
    input  logic clr,
    output logic lose_lock
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_LAST = EW'(ERR_LIMIT - 1);

    logic [CW-1:0] win_cnt_q, win_cnt_d;
    logic [EW-1:0] win_err_q, win_err_d;

    // Count enabled bits and errors in the current window; the limit-reaching error drops lock
    always_comb begin
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        lose_lock = 1'b0;
        if (!active) begin
            win_cnt_d = '0;
            win_err_d = '0;
        end else if (en) begin
            if (bit_err) begin
                if (win_err_q == ERR_LAST) begin
                    lose_lock = 1'b1;
                end
                win_err_d = win_err_q + 1'b1;
            end
            if (win_cnt_q == WIN_LAST) begin
                win_cnt_d = '0;
                win_err_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + 1'b1;
            end
            if (lose_lock) begin
                win_cnt_d = '0;
                win_err_d = '0;
            end
        end
        if (clr) begin
            win_cnt_d = '0;
            win_err_d = '0;
        end
    end

    // Window counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS checker; PRBS_CHK_BITCNT_EN adds bit_count
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int WIDTH     = PRBS_WIDTH,
    parameter int TAP_A     = PRBS_TAP_A,
    parameter int TAP_B     = PRBS_TAP_B,
    parameter int SYNC_LEN  = 8,
    parameter int WINDOW    = 16,
    parameter int ERR_LIMIT = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data_in,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
`ifdef PRBS_CHK_BITCNT_EN
    output logic [CNT_W-1:0] bit_count,
`endif
    output logic [CNT_W-1:0] err_count
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int M_W    = $clog2(SYNC_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(WIDTH);
    localparam logic [M_W-1:0]    MATCH_LAST = M_W'(SYNC_LEN - 1);

    prbs_state_t        state_q, state_d;
    logic [WIDTH-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [M_W-1:0]     match_q, match_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic predicted;
    logic bit_err;
    logic lose_lock;

    assign predicted = prbs_predict(32'(hist_q), TAP_A, TAP_B);
    assign bit_err   = en && (state_q == LOCKED) && (data_in != predicted);

    prbs_win_mon #(
        .WINDOW    (WINDOW),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_win_mon (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .active    (state_q == LOCKED),
        .bit_err   (bit_err),
        .clr       (clr),
        .lose_lock (lose_lock)
    );

    // Next state: search by matching the recurrence, then flywheel on the prediction once locked
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_d     = match_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        if (en) begin
            case (state_q)
                SEARCH: begin
                    hist_d = {hist_q[WIDTH-2:0], data_in};
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 1'b1;
                    end
                    if ((fill_q == FILL_FULL) && (hist_q != '0) && (data_in == predicted)) begin
                        if (match_q == MATCH_LAST) begin
                            state_d = LOCKED;
                            match_d = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    hist_d = {hist_q[WIDTH-2:0], predicted};
                    if (bit_err) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != {CNT_W{1'b1}}) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                    end
                    if (lose_lock) begin
                        state_d = SEARCH;
                        hist_d  = '0;
                        fill_d  = '0;
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
        if (clr) begin
            err_count_d = '0;
        end
    end

    // State, history and error-count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

`ifdef PRBS_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_count_q, bit_count_d;

    // Saturating count of enabled bits sampled while locked, for BER
    always_comb begin
        bit_count_d = bit_count_q;
        if (en && (state_q == LOCKED) && (bit_count_q != {CNT_W{1'b1}})) begin
            bit_count_d = bit_count_q + 1'b1;
        end
        if (clr) begin
            bit_count_d = '0;
        end
    end

    // Bit counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_count_q <= '0;
        end else begin
            bit_count_q <= bit_count_d;
        end
    end

    assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed self-checking bench for prbs_checker
module tb_prbs_checker;

    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             en;
    logic             data_in;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
`ifdef PRBS_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] g;

    prbs_checker #(
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
`ifdef PRBS_CHK_BITCNT_EN
        .bit_count (bit_count),
`endif
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic d, input logic c);
        en      = e;
        data_in = d;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    // Generator: b[n] = b[n-4] ^ b[n-3], seed 0001, first bits 0,0,1,1,...
    task automatic send(input logic inv, input logic c);
        logic b;
        b = g[3] ^ g[2];
        g = {g[2:0], b};
        step(1'b1, b ^ inv, c);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en      = 1'b0;
        data_in = 1'b0;
        clr     = 1'b0;
        g       = 4'b0001;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int bad;
        logic lk;

        // 1: reset state and clean lock at bit 12
        do_reset();
        check("rst_locked", 32'(locked), 0);
        check("rst_pulse", 32'(err_pulse), 0);
        check("rst_count", 32'(err_count), 0);
        bad = 0;
        for (int i = 1; i <= 300; i++) begin
            send(1'b0, 1'b0);
            if (i == 11) check("t1_lock_b11", 32'(locked), 0);
            if (i == 12) check("t1_lock_b12", 32'(locked), 1);
            if (i > 12 && (locked !== 1'b1 || err_pulse !== 1'b0)) bad++;
        end
        check("t1_clean_run", 32'(bad), 0);
        check("t1_err_count", 32'(err_count), 0);
`ifdef PRBS_CHK_BITCNT_EN
        check("t1_bit_count_sat", 32'(bit_count), 7);
`endif

        // 2: single inverted bit while locked
        send(1'b1, 1'b0);
        check("t2_pulse", 32'(err_pulse), 1);
        check("t2_count", 32'(err_count), 1);
        check("t2_locked", 32'(locked), 1);
        send(1'b0, 1'b0);
        check("t2_pulse_end", 32'(err_pulse), 0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            send(1'b0, 1'b0);
            if (err_pulse !== 1'b0 || locked !== 1'b1) bad++;
        end
        check("t2_no_followon", 32'(bad), 0);
        check("t2_count_hold", 32'(err_count), 1);

        // 3: four errors in one window drop lock, relock after 12 clean bits
        do_reset();
        for (int i = 1; i <= 12; i++) send(1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            send((k == 4 || k == 6 || k == 8 || k == 10), 1'b0);
            if (k == 8) check("t3_locked_3rd", 32'(locked), 1);
        end
        check("t3_unlock", 32'(locked), 0);
        check("t3_count", 32'(err_count), 4);
        for (int i = 1; i <= 12; i++) begin
            send(1'b0, 1'b0);
            if (i == 11) check("t3_relock_b11", 32'(locked), 0);
        end
        check("t3_relock_b12", 32'(locked), 1);
        check("t3_count_kept", 32'(err_count), 4);

        // 4: all-zero input never locks
        do_reset();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (locked !== 1'b0) bad++;
        end
        check("t4_zero_nolock", 32'(bad), 0);

        // 5: en toggling gives the same lock point in en bits; idle cycles change nothing
        do_reset();
        bad = 0;
        for (int i = 1; i <= 12; i++) begin
            send(1'b0, 1'b0);
            if (i == 11) check("t5_lock_b11", 32'(locked), 0);
            lk = locked;
            step(1'b0, 1'(i & 1), 1'b0);
            if (locked !== lk || err_pulse !== 1'b0) bad++;
        end
        check("t5_lock_b12", 32'(locked), 1);
        send(1'b1, 1'b0);
        check("t5_err_pulse", 32'(err_pulse), 1);
        step(1'b0, 1'b1, 1'b0);
        check("t5_idle_pulse", 32'(err_pulse), 0);
        check("t5_idle_count", 32'(err_count), 1);
        check("t5_idle_run", 32'(bad), 0);

        // 6: saturation at all-ones, then clr together with an error
        do_reset();
        for (int i = 1; i <= 12; i++) send(1'b0, 1'b0);
        for (int k = 1; k <= 48; k++) begin
            send(((k - 1) % 16 == 0) || ((k - 1) % 16 == 2) || ((k - 1) % 16 == 4), 1'b0);
            if (k == 33) check("t6_count_7", 32'(err_count), 7);
        end
        check("t6_sat_hold", 32'(err_count), 7);
        check("t6_sat_locked", 32'(locked), 1);
        send(1'b1, 1'b1);
        check("t6_clr_count", 32'(err_count), 0);
        check("t6_clr_pulse", 32'(err_pulse), 1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("t6_count_after_clr", 32'(err_count), 1);

        // rst mid-lock returns everything to zero
        rst = 1'b1;
        send(1'b1, 1'b0);
        rst = 1'b0;
        check("rst_mid_locked", 32'(locked), 0);
        check("rst_mid_pulse", 32'(err_pulse), 0);
        check("rst_mid_count", 32'(err_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
